// File: rtl/eeg_epoch_sequencer.sv
// eeg_epoch_sequencer: captures one sleep epoch of ADC EEG samples into the
// intermediate-results memory (converted to compute fixed-point on the way in)
// and launches inference on the CiM compute engine on each new sleep epoch.
// Optional compute watchdog: define SEQ_WATCHDOG_EN.
module eeg_epoch_sequencer #(
    parameter int NUM_SAMPLES   = 3000,
    parameter int EEG_BASE_ADDR = 0,
    parameter int FRAC_BITS     = 5,
    parameter int WDT_CYCLES    = 1 << 20,
    parameter int ADDR_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_eeg_load,
    input  logic              new_eeg_data,
    input  logic [15:0]       eeg,
    input  logic              new_sleep_epoch,
    output logic              inference_complete,
    output logic              wr_req,
    input  logic              wr_gnt,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [21:0]       wr_data,
    output logic [1:0]        wr_width,
    output logic              compute_start,
    input  logic              compute_done,
    output logic              busy,
    output logic              overrun,
    output logic              wdt_timeout
);

    localparam int ADC_W = 16;
    localparam int FX_W  = 22;
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam logic [1:0] SINGLE_WIDTH = 2'd0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_INFER = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Zero-extend, shift into fixed-point, clamp to the largest positive code.
    function automatic logic [FX_W-1:0] adc_to_fx(input logic [ADC_W-1:0] code);
        logic [63:0] wide;
        logic [63:0] fx_max;
        wide   = 64'(code) << FRAC_BITS;
        fx_max = (64'd1 << (FX_W - 1)) - 64'd1;
        if (wide > fx_max) begin
            adc_to_fx = fx_max[FX_W-1:0];
        end else begin
            adc_to_fx = wide[FX_W-1:0];
        end
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_adv_s;
    logic              wr_req_q, wr_req_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [FX_W-1:0]   wr_data_q, wr_data_d;
    logic              overrun_q, overrun_d;
    logic              compute_start_q, compute_start_d;
    logic              inference_complete_q, inference_complete_d;
    logic              busy_q, busy_d;
    logic              granted_s;
`ifdef SEQ_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0]  wdt_cnt_q, wdt_cnt_d;
    logic              wdt_timeout_q, wdt_timeout_d;
`endif

    // Next-state, write-port and flag logic for the epoch sequencer.
    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        cnt_adv_s            = cnt_q;
        wr_req_d             = wr_req_q;
        wr_addr_d            = wr_addr_q;
        wr_data_d            = wr_data_q;
        overrun_d            = overrun_q;
        compute_start_d      = 1'b0;
        inference_complete_d = 1'b0;
        granted_s            = wr_req_q && wr_gnt;
`ifdef SEQ_WATCHDOG_EN
        wdt_cnt_d            = wdt_cnt_q;
        wdt_timeout_d        = wdt_timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_eeg_load) begin
                    state_d   = S_LOAD;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
`ifdef SEQ_WATCHDOG_EN
                    wdt_timeout_d = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // A grant retires the held sample and frees the holding register.
                if (granted_s) begin
                    cnt_adv_s = cnt_q + CNT_W'(1);
                    wr_req_d  = 1'b0;
                end else begin
                    cnt_adv_s = cnt_q;
                end
                if (new_eeg_data) begin
                    if (wr_req_q && !wr_gnt) begin
                        overrun_d = 1'b1;
                    end else if (cnt_adv_s < CNT_W'(NUM_SAMPLES)) begin
                        wr_req_d  = 1'b1;
                        wr_addr_d = ADDR_W'(EEG_BASE_ADDR) + ADDR_W'(cnt_adv_s);
                        wr_data_d = adc_to_fx(eeg);
                    end else begin
                        // Epoch already complete: no slot for this sample.
                        overrun_d = 1'b1;
                    end
                end else begin
                    overrun_d = overrun_q;
                end
                cnt_d = cnt_adv_s;
                if (granted_s && (cnt_q == CNT_W'(NUM_SAMPLES - 1))) begin
                    state_d = S_READY;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_READY: begin
                if (new_eeg_data) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (new_sleep_epoch) begin
                    state_d         = S_INFER;
                    compute_start_d = 1'b1;
`ifdef SEQ_WATCHDOG_EN
                    wdt_cnt_d       = '0;
`endif
                end else begin
                    state_d = S_READY;
                end
            end
            S_INFER: begin
                if (new_eeg_data) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (compute_done) begin
                    state_d              = S_DONE;
                    inference_complete_d = 1'b1;
                end
`ifdef SEQ_WATCHDOG_EN
                else if (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1)) begin
                    state_d       = S_IDLE;
                    wdt_timeout_d = 1'b1;
                end else begin
                    wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
                end
`else
                else begin
                    state_d = S_INFER;
                end
`endif
            end
            S_DONE: begin
                if (new_eeg_data) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                // Re-arm for the next epoch immediately; flags stay sticky.
                state_d = S_LOAD;
                cnt_d   = '0;
            end
            default: begin
                state_d  = S_IDLE;
                wr_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; async reset abandons any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q              <= S_IDLE;
            cnt_q                <= '0;
            wr_req_q             <= 1'b0;
            wr_addr_q            <= '0;
            wr_data_q            <= '0;
            overrun_q            <= 1'b0;
            compute_start_q      <= 1'b0;
            inference_complete_q <= 1'b0;
            busy_q               <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wdt_cnt_q            <= '0;
            wdt_timeout_q        <= 1'b0;
`endif
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            wr_req_q             <= wr_req_d;
            wr_addr_q            <= wr_addr_d;
            wr_data_q            <= wr_data_d;
            overrun_q            <= overrun_d;
            compute_start_q      <= compute_start_d;
            inference_complete_q <= inference_complete_d;
            busy_q               <= busy_d;
`ifdef SEQ_WATCHDOG_EN
            wdt_cnt_q            <= wdt_cnt_d;
            wdt_timeout_q        <= wdt_timeout_d;
`endif
        end
    end

    assign wr_req             = wr_req_q;
    assign wr_addr            = wr_addr_q;
    assign wr_data            = wr_data_q;
    assign wr_width           = SINGLE_WIDTH;
    assign overrun            = overrun_q;
    assign compute_start      = compute_start_q;
    assign inference_complete = inference_complete_q;
    assign busy               = busy_q;
`ifdef SEQ_WATCHDOG_EN
    assign wdt_timeout        = wdt_timeout_q;
`else
    assign wdt_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_eeg_epoch_sequencer.sv
// Self-checking bench for eeg_epoch_sequencer: a table of load-phase vectors
// plus directed sequences for full epoch load, inference handshake, ignored
// events, mid-inference reset and (with SEQ_WATCHDOG_EN) the watchdog.
module tb_eeg_epoch_sequencer;

    localparam int NS = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_eeg_load = 1'b0;
    logic        new_eeg_data = 1'b0;
    logic [15:0] eeg = 16'd0;
    logic        new_sleep_epoch = 1'b0;
    logic        inference_complete;
    logic        wr_req;
    logic        wr_gnt = 1'b0;
    logic [15:0] wr_addr;
    logic [21:0] wr_data;
    logic [1:0]  wr_width;
    logic        compute_start;
    logic        compute_done = 1'b0;
    logic        busy;
    logic        overrun;
    logic        wdt_timeout;

    int tests = 0;
    int fails = 0;

    eeg_epoch_sequencer #(
        .NUM_SAMPLES(NS), .EEG_BASE_ADDR(0), .FRAC_BITS(5), .WDT_CYCLES(100), .ADDR_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_eeg_load(start_eeg_load),
        .new_eeg_data(new_eeg_data), .eeg(eeg), .new_sleep_epoch(new_sleep_epoch),
        .inference_complete(inference_complete), .wr_req(wr_req), .wr_gnt(wr_gnt),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_width(wr_width),
        .compute_start(compute_start), .compute_done(compute_done), .busy(busy),
        .overrun(overrun), .wdt_timeout(wdt_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        nd;
        logic [15:0] code;
        logic        gnt;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic [21:0] exp_data;
        logic        exp_ov;
    } vec_t;

    vec_t tbl[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " wr_req"}, 32'(wr_req), 32'd0);
        check({tag, " wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, " wr_data"}, 32'(wr_data), 32'd0);
        check({tag, " wr_width"}, 32'(wr_width), 32'd0);
        check({tag, " compute_start"}, 32'(compute_start), 32'd0);
        check({tag, " inference_complete"}, 32'(inference_complete), 32'd0);
        check({tag, " overrun"}, 32'(overrun), 32'd0);
        check({tag, " wdt_timeout"}, 32'(wdt_timeout), 32'd0);
    endtask

    // Full epoch with wr_gnt tied high; optional ignored new_sleep_epoch at 1500.
    task automatic load_epoch();
        int cs_seen;
        cs_seen = 0;
        wr_gnt = 1'b1;
        for (int i = 0; i < NS; i++) begin
            new_eeg_data = 1'b1;
            eeg = 16'(i);
            new_sleep_epoch = (i == 1500) ? 1'b1 : 1'b0;
            tick();
            if (compute_start) cs_seen++;
            check("load wr_req", 32'(wr_req), 32'd1);
            check("load wr_addr", 32'(wr_addr), 32'(i));
            check("load wr_data", 32'(wr_data), 32'(i * 32));
        end
        new_eeg_data = 1'b0;
        new_sleep_epoch = 1'b0;
        tick();
        check("load final wr_req", 32'(wr_req), 32'd0);
        check("load busy", 32'(busy), 32'd1);
        check("ignored sleep epoch in LOAD", 32'(cs_seen), 32'd0);
        wr_gnt = 1'b0;
    endtask

    initial begin
        int cs_count;
        tbl[0]  = '{1'b1, 16'd7,      1'b0, 1'b1, 16'd0, 22'd224,     1'b0};
        tbl[1]  = '{1'b0, 16'd0,      1'b0, 1'b1, 16'd0, 22'd224,     1'b0};
        tbl[2]  = '{1'b0, 16'd0,      1'b0, 1'b1, 16'd0, 22'd224,     1'b0};
        tbl[3]  = '{1'b0, 16'd0,      1'b0, 1'b1, 16'd0, 22'd224,     1'b0};
        tbl[4]  = '{1'b1, 16'd9,      1'b0, 1'b1, 16'd0, 22'd224,     1'b1};
        tbl[5]  = '{1'b1, 16'd11,     1'b0, 1'b1, 16'd0, 22'd224,     1'b1};
        tbl[6]  = '{1'b0, 16'd0,      1'b1, 1'b0, 16'd0, 22'd224,     1'b1};
        tbl[7]  = '{1'b1, 16'hFFFF,   1'b0, 1'b1, 16'd1, 22'd2097120, 1'b1};
        tbl[8]  = '{1'b1, 16'd3,      1'b1, 1'b1, 16'd2, 22'd96,      1'b1};
        tbl[9]  = '{1'b0, 16'd0,      1'b1, 1'b0, 16'd2, 22'd96,      1'b1};
        tbl[10] = '{1'b0, 16'd0,      1'b1, 1'b0, 16'd2, 22'd96,      1'b1};
        tbl[11] = '{1'b1, 16'd5,      1'b1, 1'b1, 16'd3, 22'd160,     1'b1};
        tbl[12] = '{1'b0, 16'd0,      1'b1, 1'b0, 16'd3, 22'd160,     1'b1};

        // Reset state.
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // new_eeg_data in IDLE is ignored without overrun.
        new_eeg_data = 1'b1;
        eeg = 16'd77;
        tick();
        new_eeg_data = 1'b0;
        check("idle sample wr_req", 32'(wr_req), 32'd0);
        check("idle sample overrun", 32'(overrun), 32'd0);
        check("idle busy", 32'(busy), 32'd0);

        // Arm loading.
        start_eeg_load = 1'b1;
        tick();
        start_eeg_load = 1'b0;
        check("armed busy", 32'(busy), 32'd1);
        check("armed wr_req", 32'(wr_req), 32'd0);

        // Table: held write, stalled grant, drops, same-cycle grant+capture.
        for (int v = 0; v < 13; v++) begin
            new_eeg_data = tbl[v].nd;
            eeg = tbl[v].code;
            wr_gnt = tbl[v].gnt;
            tick();
            check($sformatf("vec%0d wr_req", v), 32'(wr_req), 32'(tbl[v].exp_req));
            check($sformatf("vec%0d wr_addr", v), 32'(wr_addr), 32'(tbl[v].exp_addr));
            check($sformatf("vec%0d wr_data", v), 32'(wr_data), 32'(tbl[v].exp_data));
            check($sformatf("vec%0d overrun", v), 32'(overrun), 32'(tbl[v].exp_ov));
        end
        new_eeg_data = 1'b0;
        wr_gnt = 1'b0;

        // Reset mid-LOAD, then a clean full epoch.
        rst_n = 1'b0;
        #1;
        check_all_zero("reset in LOAD");
        tick();
        rst_n = 1'b1;
        start_eeg_load = 1'b1;
        tick();
        start_eeg_load = 1'b0;
        load_epoch();
        check("epoch overrun", 32'(overrun), 32'd0);

        // Inference: done 40 cycles after new_sleep_epoch.
        cs_count = 0;
        new_sleep_epoch = 1'b1;
        tick();
        new_sleep_epoch = 1'b0;
        check("compute_start pulse", 32'(compute_start), 32'd1);
        if (compute_start) cs_count++;
        for (int c = 0; c < 39; c++) begin
            tick();
            if (compute_start) cs_count++;
        end
        check("compute_start width", 32'(cs_count), 32'd1);
        check("no early complete", 32'(inference_complete), 32'd0);
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        check("inference_complete", 32'(inference_complete), 32'd1);
        tick();
        check("inference_complete width", 32'(inference_complete), 32'd0);
        check("DONE->LOAD busy", 32'(busy), 32'd1);
        // Back in LOAD with cnt cleared: next sample goes to address 0.
        new_eeg_data = 1'b1;
        eeg = 16'd42;
        tick();
        new_eeg_data = 1'b0;
        check("reload wr_addr", 32'(wr_addr), 32'd0);
        check("reload wr_data", 32'(wr_data), 32'd1344);
        check("reload wr_req", 32'(wr_req), 32'd1);
        check("reload overrun", 32'(overrun), 32'd0);
        wr_gnt = 1'b1;
        tick();
        wr_gnt = 1'b0;

        // Second epoch from cnt=1 would misalign; restart cleanly via reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        start_eeg_load = 1'b1;
        tick();
        start_eeg_load = 1'b0;
        load_epoch();

        // READY: sample sets overrun; start_eeg_load and compute_done ignored.
        new_eeg_data = 1'b1;
        tick();
        new_eeg_data = 1'b0;
        check("READY overrun", 32'(overrun), 32'd1);
        start_eeg_load = 1'b1;
        compute_done = 1'b1;
        tick();
        start_eeg_load = 1'b0;
        compute_done = 1'b0;
        check("start ignored outside IDLE", 32'(overrun), 32'd1);
        tick();
        check("done ignored outside INFER", 32'(inference_complete), 32'd0);

        // INFER, then reset mid-inference; late compute_done ignored.
        new_sleep_epoch = 1'b1;
        tick();
        new_sleep_epoch = 1'b0;
        check("second compute_start", 32'(compute_start), 32'd1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset in INFER");
        tick();
        rst_n = 1'b1;
        tick();
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        tick();
        check("late done complete", 32'(inference_complete), 32'd0);
        check("late done busy", 32'(busy), 32'd0);

`ifdef SEQ_WATCHDOG_EN
        // Watchdog: 100 cycles in INFER without compute_done.
        start_eeg_load = 1'b1;
        tick();
        start_eeg_load = 1'b0;
        load_epoch();
        new_sleep_epoch = 1'b1;
        tick();
        new_sleep_epoch = 1'b0;
        for (int c = 0; c < 99; c++) begin
            tick();
        end
        check("wdt not yet", 32'(wdt_timeout), 32'd0);
        check("wdt still busy", 32'(busy), 32'd1);
        tick();
        check("wdt_timeout", 32'(wdt_timeout), 32'd1);
        check("wdt idle", 32'(busy), 32'd0);
        check("wdt no complete", 32'(inference_complete), 32'd0);
`else
        check("wdt tied low", 32'(wdt_timeout), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eeg_epoch_sequencer.md
# eeg_epoch_sequencer

Top-level sequencer between the SoC control interface and the centralized CiM compute engine. It captures one sleep epoch of ADC EEG samples into the intermediate-results memory and converts each to compute fixed-point on the way in. On each `new_sleep_epoch` it launches inference on the compute engine and reports completion back to the SoC.

## Interface
Parameters:
- `NUM_SAMPLES`, 3000: samples per epoch.
- `EEG_BASE_ADDR`, 0: int-res address of sample 0.
- `FRAC_BITS`, 5: left shift applied to ADC code on conversion.
- `WDT_CYCLES`, 2^20: compute watchdog limit. Used only with the macro in Configuration.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_eeg_load` in 1: one-cycle pulse that arms loading.
- `new_eeg_data` in 1: one-cycle pulse; `eeg` is valid this cycle.
- `eeg` in AdcData_t (16, unsigned): ADC code.
- `new_sleep_epoch` in 1: one-cycle pulse requesting inference.
- `inference_complete` out 1: one-cycle pulse.
- `wr_req` out 1: int-res write request.
- `wr_gnt` in 1: write accepted this cycle.
- `wr_addr` out IntResAddr_t: write address.
- `wr_data` out CompFx_t (22, signed): write data.
- `wr_width` out DataWidth_t: always SINGLE_WIDTH.
- `compute_start` out 1: one-cycle pulse.
- `compute_done` in 1: one-cycle pulse from the engine.
- `busy` out 1: high whenever state is not IDLE.
- `overrun` out 1: sticky error flag.
- `wdt_timeout` out 1: sticky error flag. Tied 0 without the macro.

## Operation
State machine transitions:
- IDLE -> LOAD on `start_eeg_load`. Clears `cnt`, `overrun` and `wdt_timeout`.
- LOAD -> READY once the write for sample `NUM_SAMPLES-1` is granted.
- READY -> INFER on `new_sleep_epoch`.
- INFER -> DONE on `compute_done`.
- DONE -> LOAD after one cycle. Clears `cnt`; the flags are not cleared. This gives continuous epoch operation.

Loading:
- In LOAD, `new_eeg_data` captures the converted sample into a one-entry holding register with `wr_addr = EEG_BASE_ADDR + cnt`, and asserts `wr_req`.
- `wr_req` holds until `wr_gnt`. On grant: `cnt` increments and `wr_req` drops, unless a new sample is captured the same cycle.

Conversion:
- `wr_data = {zero-ext eeg} << FRAC_BITS`.
- If the result exceeds the CompFx_t maximum positive value, saturate to that maximum. No saturation occurs with default widths.

Overrun:
- `new_eeg_data` while `wr_req && !wr_gnt` drops the new sample and sets `overrun`.
- `new_eeg_data` in READY, INFER or DONE also drops the sample and sets `overrun`.
- `new_eeg_data` in IDLE is ignored without setting the flag.

Ignored events:
- `new_sleep_epoch` outside READY is ignored. It is not queued.
- `start_eeg_load` outside IDLE is ignored.
- `compute_done` outside INFER is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt` 0, `wr_addr` 0, `wr_data` 0.
- Sample-to-write latency: `new_eeg_data` at cycle N -> `wr_req`, `wr_addr` and `wr_data` valid at N+1. The earliest grant is N+1.
- Same-cycle `wr_gnt` and `new_eeg_data`: the held write completes, the new sample is loaded at N+1, and no overrun is flagged.
- LOAD -> READY one cycle after the final grant.
- `new_sleep_epoch` at cycle M -> state INFER at M+1; `compute_start` is high during M+1 only.
- `compute_done` at cycle K -> `inference_complete` high during K+1 (DONE); LOAD at K+2.
- `cnt` never wraps; the last address is `EEG_BASE_ADDR + NUM_SAMPLES-1`.
- Reset mid-operation:
  - all state clears immediately;
  - any pending `wr_req` is abandoned;
  - a `compute_done` arriving afterwards is ignored.

## Configuration
- `SEQ_WATCHDOG_EN` defined:
  - a counter runs in INFER;
  - on reaching `WDT_CYCLES` without `compute_done`, set `wdt_timeout` and go to IDLE;
  - `inference_complete` is not pulsed.
- `SEQ_WATCHDOG_EN` undefined:
  - no counter;
  - INFER waits indefinitely;
  - `wdt_timeout` is constant 0.

## Test plan
- Reset then `start_eeg_load`, 3000 samples with `eeg = i` and `wr_gnt` tied 1 -> writes to addresses 0..2999 with data `i << 5`; state READY; `overrun` = 0.
- Hold `wr_gnt` = 0 for 3 cycles, then pulse `new_eeg_data` twice -> first sample held, second dropped, `overrun` = 1. After grant, `cnt` advances by 1 only.
- From READY, pulse `new_sleep_epoch`, then return `compute_done` 40 cycles later -> `compute_start` 1-cycle pulse, `inference_complete` 1 cycle after done, state LOAD with `cnt` = 0.
- Pulse `new_sleep_epoch` during LOAD at `cnt` = 1500 -> ignored, no `compute_start`.
- Assert `rst_n` low during INFER, release, then pulse `compute_done` -> all outputs 0, state IDLE, no `inference_complete`.
- With `SEQ_WATCHDOG_EN` and `WDT_CYCLES` = 100, no `compute_done` -> `wdt_timeout` = 1 after 100 cycles in INFER, state IDLE, no `inference_complete`.
